sd_spi_cmd_engine: RTL and testbench



---
 rtl/sd_spi_pkg.sv | 16 +
 rtl/spi_byte_shifter.sv | 71 +++++++
 rtl/sd_spi_cmd_engine.sv | 136 +++++++++++++
 tb/tb_sd_spi_cmd_engine.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SPI-mode SD command engine.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_POLL,
    ST_XFER,
    ST_DONE
  } state_t;

  localparam logic [1:0] OP_CMD    = 2'b01;
  localparam logic [1:0] OP_RAW    = 2'b11;
  localparam logic [7:0] IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_byte_shifter.sv
// Full-duplex MSB-first SPI mode-0 byte shifter with a CLK_DIV half-period divider.
// A go coinciding with done_c chains the next byte with no idle gap.
module spi_byte_shifter
  import sd_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       done_c
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic          active;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [6:0]    tx_sh;
  logic          phase_end_c;

  assign phase_end_c = active && (cnt == DIV_LAST);
  assign done_c      = phase_end_c && sclk && (bit_idx == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      tx_sh   <= '1;
      rx_byte <= IDLE_BYTE;
      sclk    <= 1'b0;
      mosi    <= 1'b1;
    end else if (go && (!active || done_c)) begin
      active  <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      tx_sh   <= tx_byte[6:0];
      mosi    <= tx_byte[7];
      sclk    <= 1'b0;
    end else if (active) begin
      if (!phase_end_c) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        if (!sclk) begin
          // miso is sampled on the same clk edge that raises sclk
          sclk    <= 1'b1;
          rx_byte <= {rx_byte[6:0], miso};
        end else begin
          sclk <= 1'b0;
          if (bit_idx == 3'd7) begin
            active <= 1'b0;
            mosi   <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            mosi    <= tx_sh[6];
            tx_sh   <= {tx_sh[5:0], 1'b1};
          end
        end
      end
    end
  end

endmodule

// File: rtl/sd_spi_cmd_engine.sv
// SPI-mode SD command engine: sends a 48-bit command and polls for the response byte,
// or performs a single raw (CS low) or idle-clock (CS high) byte transfer.
module sd_spi_cmd_engine
  import sd_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned RESP_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] cmd,
  input  logic        start,
  output logic [7:0]  response,
  output logic        responseByte,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  localparam int unsigned PW = $clog2(RESP_TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [47:0]   cmd_q, cmd_nxt;
  logic [2:0]    left_q, left_nxt;
  logic [PW-1:0] poll_q, poll_nxt;
  logic          start_q;
  logic          busy_nxt, cs_n_nxt, rb_nxt;
  logic [7:0]    resp_nxt;
  logic          go_c, done_c;
  logic [7:0]    tx_c, rx_byte;

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .go      (go_c),
    .tx_byte (tx_c),
    .miso    (miso),
    .sclk    (sclk),
    .mosi    (mosi),
    .rx_byte (rx_byte),
    .done_c  (done_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cmd_q        <= '0;
      left_q       <= '0;
      poll_q       <= '0;
      start_q      <= 1'b1;
      busy         <= 1'b0;
      cs_n         <= 1'b1;
      response     <= IDLE_BYTE;
      responseByte <= 1'b0;
    end else begin
      state        <= state_nxt;
      cmd_q        <= cmd_nxt;
      left_q       <= left_nxt;
      poll_q       <= poll_nxt;
      start_q      <= start;
      busy         <= busy_nxt;
      cs_n         <= cs_n_nxt;
      response     <= resp_nxt;
      responseByte <= rb_nxt;
    end
  end

  // cmd_q holds the not-yet-sent command bytes, left-aligned
  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    left_nxt  = left_q;
    poll_nxt  = poll_q;
    busy_nxt  = busy;
    cs_n_nxt  = cs_n;
    resp_nxt  = response;
    rb_nxt    = responseByte;
    go_c      = 1'b0;
    tx_c      = IDLE_BYTE;
    case (state)
      ST_IDLE: begin
        if (start && !start_q) begin
          go_c     = 1'b1;
          busy_nxt = 1'b1;
          cmd_nxt  = {cmd[39:0], 8'h00};
          left_nxt = 3'd5;
          poll_nxt = '0;
          if (cmd[47:46] == OP_CMD) begin
            state_nxt = ST_SEND;
            cs_n_nxt  = 1'b0;
            tx_c      = cmd[47:40];
          end else begin
            state_nxt = ST_XFER;
            cs_n_nxt  = (cmd[47:46] != OP_RAW);
          end
        end
      end
      ST_SEND: begin
        if (done_c) begin
          go_c = 1'b1;
          if (left_q == 3'd0) begin
            state_nxt = ST_POLL;
            poll_nxt  = PW'(1);
          end else begin
            tx_c     = cmd_q[47:40];
            cmd_nxt  = {cmd_q[39:0], 8'h00};
            left_nxt = left_q - 1'b1;
          end
        end
      end
      ST_POLL: begin
        if (done_c) begin
          if ((rx_byte != IDLE_BYTE) || (poll_q == PW'(RESP_TIMEOUT))) begin
            state_nxt = ST_DONE;
          end else begin
            go_c     = 1'b1;
            poll_nxt = PW'(poll_q + 1'b1);
          end
        end
      end
      ST_XFER: begin
        if (done_c) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        resp_nxt  = rx_byte;
        rb_nxt    = ~responseByte;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Directed bench for sd_spi_cmd_engine with a simple SPI card model on miso.
module tb_sd_spi_cmd_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] cmd;
  logic        start;
  logic [7:0]  response;
  logic        responseByte;
  logic        busy;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        cs_n;

  int n_cmp = 0;
  int n_bad = 0;

  // monitor counters, each written by one process only
  int rises = 0, falls = 0, toggles = 0, mosi_chg = 0, cs_hi = 0, cs_lo = 0, busy_rises = 0;
  logic [127:0] mosi_stream = '0;

  // snapshots taken by the stimulus process
  int b_rises, b_toggles, b_mosi_chg, b_cs_hi, b_cs_lo, b_busy_rises;
  int miso_base = 0, miso_len = 0;
  logic [0:127] miso_bits = '1;

  sd_spi_cmd_engine #(.CLK_DIV(2), .RESP_TIMEOUT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd),
    .start        (start),
    .response     (response),
    .responseByte (responseByte),
    .busy         (busy),
    .sclk         (sclk),
    .mosi         (mosi),
    .miso         (miso),
    .cs_n         (cs_n)
  );

  always #5 clk = ~clk;

  always @(posedge sclk) begin
    rises++;
    mosi_stream = {mosi_stream[126:0], mosi};
  end
  always @(negedge sclk) falls++;
  always @(responseByte) if (!reset) toggles++;
  always @(mosi) if (!reset) mosi_chg++;
  always @(posedge busy) busy_rises++;
  always @(negedge clk) if (busy) begin
    if (cs_n) cs_hi++;
    else cs_lo++;
  end

  // card model: next bit is presented after each sclk falling edge
  always_comb begin
    int idx;
    idx = falls - miso_base;
    miso = (idx >= 0 && idx < miso_len) ? miso_bits[7'(idx)] : 1'b1;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    b_rises = rises; b_toggles = toggles; b_mosi_chg = mosi_chg;
    b_cs_hi = cs_hi; b_cs_lo = cs_lo; b_busy_rises = busy_rises;
  endtask

  task automatic clear_miso();
    miso_base = falls;
    miso_len  = 0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int count);
    for (int n = 0; n < count; n++) begin
      for (int i = 0; i < 8; i++) miso_bits[7'(miso_len + i)] = b[7 - i];
      miso_len += 8;
    end
  endtask

  task automatic pulse_start(input logic [47:0] c);
    @(negedge clk);
    cmd   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 3000 && busy; k++) @(negedge clk);
    check_eq({tag, "_timeout"}, 128'(busy), 128'(0));
  endtask

  task automatic run_op(input logic [47:0] c, input string tag);
    pulse_start(c);
    wait_idle(tag);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_sclk"}, 128'(sclk), 128'(0));
    check_eq({tag, "_mosi"}, 128'(mosi), 128'(1));
    check_eq({tag, "_cs_n"}, 128'(cs_n), 128'(1));
    check_eq({tag, "_busy"}, 128'(busy), 128'(0));
    check_eq({tag, "_resp"}, 128'(response), 128'(8'hFF));
    check_eq({tag, "_rb"}, 128'(responseByte), 128'(0));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cmd   = '0;
    repeat (3) @(negedge clk);
    #1 check_reset_values("rst");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // CMD0 with response after two idle poll bytes
    clear_miso(); push_byte(8'hFF, 8); push_byte(8'h01, 1);
    mark();
    run_op(48'h400000000095, "cmd0");
    check_eq("cmd0_rises", 128'(rises - b_rises), 128'(72));
    check_eq("cmd0_mosi", 128'(mosi_stream[71:0]), 128'({48'h400000000095, 24'hFFFFFF}));
    check_eq("cmd0_resp", 128'(response), 128'(8'h01));
    check_eq("cmd0_tog", 128'(toggles - b_toggles), 128'(1));
    check_eq("cmd0_cs_hi", 128'(cs_hi - b_cs_hi), 128'(0));
    check_eq("cmd0_cs_after", 128'(cs_n), 128'(0));

    // CMD8 with no answer: full poll timeout
    clear_miso();
    mark();
    run_op(48'h48000001AA87, "cmd8");
    check_eq("tmo_rises", 128'(rises - b_rises), 128'(112));
    check_eq("tmo_mosi", 128'(mosi_stream[111:0]), 128'({48'h48000001AA87, 64'hFFFFFFFFFFFFFFFF}));
    check_eq("tmo_resp", 128'(response), 128'(8'hFF));
    check_eq("tmo_tog", 128'(toggles - b_toggles), 128'(1));
    check_eq("tmo_busy", 128'(busy), 128'(0));

    // RAW byte transfer returning a data token
    clear_miso(); push_byte(8'hFE, 1);
    mark();
    run_op(48'hC00000000000, "raw");
    check_eq("raw_rises", 128'(rises - b_rises), 128'(8));
    check_eq("raw_mosi_chg", 128'(mosi_chg - b_mosi_chg), 128'(0));
    check_eq("raw_cs_hi", 128'(cs_hi - b_cs_hi), 128'(0));
    check_eq("raw_resp", 128'(response), 128'(8'hFE));
    check_eq("raw_tog", 128'(toggles - b_toggles), 128'(1));

    // second start edge while busy is dropped
    clear_miso(); push_byte(8'h5A, 1);
    mark();
    pulse_start(48'hC00000000000);
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("dbl");
    repeat (40) @(negedge clk);
    check_eq("dbl_tog", 128'(toggles - b_toggles), 128'(1));
    check_eq("dbl_busy_rises", 128'(busy_rises - b_busy_rises), 128'(1));
    check_eq("dbl_resp", 128'(response), 128'(8'h5A));

    // ten idle-clock bytes release the card
    clear_miso();
    mark();
    for (int i = 0; i < 10; i++) run_op(48'h0, "idle8");
    check_eq("idle_rises", 128'(rises - b_rises), 128'(80));
    check_eq("idle_cs_lo", 128'(cs_lo - b_cs_lo), 128'(0));
    check_eq("idle_tog", 128'(toggles - b_toggles), 128'(10));
    check_eq("idle_resp", 128'(response), 128'(8'hFF));
    check_eq("idle_cs_after", 128'(cs_n), 128'(1));

    // start held high across reset release does not trigger
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    cmd   = 48'h400000000095;
    repeat (2) @(negedge clk);
    mark();
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("hold_busy_rises", 128'(busy_rises - b_busy_rises), 128'(0));
    check_eq("hold_rises", 128'(rises - b_rises), 128'(0));
    check_eq("hold_tog", 128'(toggles - b_toggles), 128'(0));
    start = 1'b0;
    repeat (3) @(negedge clk);

    // reset during the fourth command byte aborts without a toggle
    clear_miso();
    mark();
    pulse_start(48'h400000000095);
    for (int k = 0; k < 2000 && (rises - b_rises) < 28; k++) @(negedge clk);
    check_eq("abort_reach", 128'(rises - b_rises), 128'(28));
    reset = 1'b1;
    #1 check_reset_values("abort");
    check_eq("abort_tog", 128'(toggles - b_toggles), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // normal transaction after the abort
    clear_miso(); push_byte(8'hFF, 6); push_byte(8'h00, 1);
    mark();
    run_op(48'h7700000000FF, "post");
    check_eq("post_rises", 128'(rises - b_rises), 128'(56));
    check_eq("post_resp", 128'(response), 128'(8'h00));
    check_eq("post_tog", 128'(toggles - b_toggles), 128'(1));
    check_eq("post_rb", 128'(responseByte), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
